sha256_msg_sched: RTL and testbench

SHA256 message-schedule block: consumes the 16 padded words per 512-bit block produced by the padding stage (`w_vld`/`w_cnt`/`w_data`) and expands them into the 64-word schedule W0..W63. It delivers the schedule one word per handshake to the compression-round core. It drives `hash_done` back to the padding stage when a block's schedule has been fully delivered.

---
 rtl/sha256_msg_sched_pkg.sv | 24 ++
 rtl/sha256_w_window.sv | 41 ++++
 rtl/sha256_msg_sched.sv | 141 ++++++++++++++
 tb/tb_sha256_msg_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_sched_pkg.sv
// Shared SHA256 definitions: block/schedule sizes, small sigma functions and
// the message-schedule FSM state encoding.
package sha256_pkg;

  localparam int SHA256_BLK_WORDS = 16;
  localparam int SHA256_ROUNDS    = 64;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    ssig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    ssig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_window.sv
// 16-entry sliding window of schedule words. One write port, four
// combinational read ports addressed relative to the current round t
// (t, t+1, t+9, t+14, all modulo 16).
module sha256_w_window
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  t_i,
  output logic [31:0] rd_t_o,
  output logic [31:0] rd_t1_o,
  output logic [31:0] rd_t9_o,
  output logic [31:0] rd_t14_o
);

  logic [31:0] mem_q [SHA256_BLK_WORDS];

  logic [3:0] a_t1;
  logic [3:0] a_t9;
  logic [3:0] a_t14;

  // 4-bit adds wrap naturally, giving the modulo-16 window addressing.
  assign a_t1  = t_i + 4'd1;
  assign a_t9  = t_i + 4'd9;
  assign a_t14 = t_i + 4'd14;

  assign rd_t_o   = mem_q[t_i];
  assign rd_t1_o  = mem_q[a_t1];
  assign rd_t9_o  = mem_q[a_t9];
  assign rd_t14_o = mem_q[a_t14];

  // Single write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA256 message schedule: loads 16 words of a block, then streams
// W0..W63 to the round core with a valid/ready handshake.
//
// Handshake: wt_vld/wt_ready. A word transfers on a cycle where both are
// high. Once wt_vld rises it stays high, and wt_idx/wt_data stay stable,
// until that transfer happens. w_vld has no backpressure and is only
// legal in LOAD; anywhere else the word is dropped and proto_err latches.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int P_WORDS  = 16,
  parameter int P_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_vld,
  input  logic [5:0]  w_cnt,
  input  logic [31:0] w_data,
  output logic        hash_done,
  output logic        wt_vld,
  input  logic        wt_ready,
  output logic [5:0]  wt_idx,
  output logic [31:0] wt_data,
  output logic        busy,
  output logic        proto_err,
  output logic [1:0]  dbg_state
);

  localparam logic [5:0] T_LAST  = 6'(P_ROUNDS - 1);
  localparam logic [5:0] T_RECUR = 6'(P_WORDS);

  state_t     state_q, state_d;
  logic [5:0] t_q, t_d;
  logic       proto_err_q, proto_err_d;

  logic        hs;
  logic        in_recur;
  logic        win_we;
  logic [3:0]  win_waddr;
  logic [31:0] win_wdata;
  logic [31:0] rd_t, rd_t1, rd_t9, rd_t14;
  logic [31:0] sched_word;

  // Upper counter bits only track block progress in the padder.
  logic unused_w_cnt_hi;
  assign unused_w_cnt_hi = ^w_cnt[5:4];

  assign hs       = (state_q == EXPAND) && wt_ready;
  assign in_recur = (t_q >= T_RECUR);

  sha256_w_window u_window (
    .clk      (clk),
    .we_i     (win_we),
    .waddr_i  (win_waddr),
    .wdata_i  (win_wdata),
    .t_i      (t_q[3:0]),
    .rd_t_o   (rd_t),
    .rd_t1_o  (rd_t1),
    .rd_t9_o  (rd_t9),
    .rd_t14_o (rd_t14)
  );

  // Schedule word for the current t: straight from the window for the
  // first 16, otherwise the sigma recurrence over the sliding window.
  always_comb begin
    sched_word = rd_t;
    if (in_recur) begin
      sched_word = ssig1(rd_t14) + rd_t9 + ssig0(rd_t1) + rd_t;
    end
  end

  // Window write: loaded words in LOAD, recurrence results on transfer.
  always_comb begin
    win_we    = 1'b0;
    win_waddr = w_cnt[3:0];
    win_wdata = w_data;
    if (state_q == LOAD && w_vld) begin
      win_we = 1'b1;
    end else if (hs && in_recur) begin
      win_we    = 1'b1;
      win_waddr = t_q[3:0];
      win_wdata = sched_word;
    end
  end

  // Next-state and round counter logic.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    proto_err_d = proto_err_q;
    case (state_q)
      LOAD: begin
        if (w_vld && w_cnt[3:0] == 4'd15) begin
          state_d = EXPAND;
          t_d     = 6'd0;
        end
      end
      EXPAND: begin
        if (w_vld) proto_err_d = 1'b1;
        if (hs) begin
          t_d = t_q + 6'd1;
          if (t_q == T_LAST) begin
            state_d = DONE;
            t_d     = 6'd0;
          end
        end
      end
      DONE: begin
        if (w_vld) proto_err_d = 1'b1;
        state_d = LOAD;
        t_d     = 6'd0;
      end
      default: begin
        state_d = LOAD;
        t_d     = 6'd0;
      end
    endcase
  end

  // State, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      t_q         <= 6'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign wt_vld    = (state_q == EXPAND);
  assign wt_idx    = wt_vld ? t_q : 6'd0;
  assign wt_data   = wt_vld ? sched_word : 32'd0;
  assign hash_done = (state_q == DONE);
  assign busy      = (state_q != LOAD);
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for the SHA256 message schedule.
module tb_sha256_msg_sched;
  import sha256_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_vld;
  logic [5:0]  w_cnt;
  logic [31:0] w_data;
  logic        hash_done;
  logic        wt_vld;
  logic        wt_ready;
  logic [5:0]  wt_idx;
  logic [31:0] wt_data;
  logic        busy;
  logic        proto_err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] blk  [16];
  logic [31:0] gold [64];
  logic        exp_proto;

  sha256_msg_sched dut (
    .clk       (clk),
    .reset     (reset),
    .w_vld     (w_vld),
    .w_cnt     (w_cnt),
    .w_data    (w_data),
    .hash_done (hash_done),
    .wt_vld    (wt_vld),
    .wt_ready  (wt_ready),
    .wt_idx    (wt_idx),
    .wt_data   (wt_data),
    .busy      (busy),
    .proto_err (proto_err),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule from the textbook recurrence over a full 64-entry array.
  function automatic void build_gold();
    for (int i = 0; i < 16; i++) gold[i] = blk[i];
    for (int i = 16; i < 64; i++)
      gold[i] = m_s1(gold[i-2]) + gold[i-7] + m_s0(gold[i-15]) + gold[i-16];
  endfunction

  // Drivers: every task starts and ends 1 time unit after a rising edge.
  task automatic load_word(input int idx, input logic [31:0] d);
    w_vld  = 1'b1;
    w_cnt  = 6'(idx);
    w_data = d;
    @(posedge clk); #1;
    w_vld  = 1'b0;
  endtask

  task automatic load_block();
    for (int i = 0; i < 16; i++) load_word(i, blk[i]);
  endtask

  task automatic consume_block(input string name, input bit rand_rdy,
                               input int proto_at, input bit chk_abc);
    int          t;
    int          cyc;
    bit          stalled;
    bit          pulsed;
    logic [5:0]  p_idx;
    logic [31:0] p_data;
    t = 0; cyc = 0; stalled = 0; pulsed = 0;
    p_idx = '0; p_data = '0;
    while (t < 64 && cyc < 2000) begin
      checks++;
      if (wt_vld !== 1'b1 || wt_idx !== 6'(t) || wt_data !== gold[t]) begin
        failures++;
        $display("FAIL %s word: got vld=%b idx=%0d data=%08h, want vld=1 idx=%0d data=%08h",
                 name, wt_vld, wt_idx, wt_data, t, gold[t]);
      end
      if (stalled) begin
        checks++;
        if (wt_idx !== p_idx || wt_data !== p_data) begin
          failures++;
          $display("FAIL %s stall_hold: got idx=%0d data=%08h, want idx=%0d data=%08h",
                   name, wt_idx, wt_data, p_idx, p_data);
        end
      end
      if (chk_abc && (t == 16 || t == 17)) begin
        checks++;
        if (wt_data !== ((t == 16) ? 32'h61626380 : 32'h000F0000)) begin
          failures++;
          $display("FAIL %s hand_w%0d: got %08h", name, t, wt_data);
        end
      end
      checks++;
      if (proto_err !== exp_proto || hash_done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s flags: got proto_err=%b hash_done=%b busy=%b, want %b 0 1",
                 name, proto_err, hash_done, busy, exp_proto);
      end
      if (t == proto_at && !pulsed) begin
        w_vld  = 1'b1;
        w_cnt  = 6'd5;
        w_data = 32'hdeadbeef;
        pulsed = 1'b1;
      end
      wt_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      p_idx    = wt_idx;
      p_data   = wt_data;
      stalled  = !wt_ready;
      if (wt_ready) t++;
      @(posedge clk); #1;
      if (w_vld) exp_proto = 1'b1;
      w_vld = 1'b0;
      cyc++;
    end
    wt_ready = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      failures++;
      $display("FAIL %s timeout: got %0d words, want 64", name, t);
    end
    checks++;
    if (hash_done !== 1'b1 || wt_vld !== 1'b0 || busy !== 1'b1 || wt_data !== 32'd0) begin
      failures++;
      $display("FAIL %s done_pulse: got hash_done=%b wt_vld=%b busy=%b data=%08h, want 1 0 1 0",
               name, hash_done, wt_vld, busy, wt_data);
    end
    @(posedge clk); #1;
    checks++;
    if (hash_done !== 1'b0 || busy !== 1'b0 || dbg_state !== LOAD || proto_err !== exp_proto) begin
      failures++;
      $display("FAIL %s back_to_load: got hash_done=%b busy=%b state=%0d perr=%b, want 0 0 0 %b",
               name, hash_done, busy, dbg_state, proto_err, exp_proto);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; w_vld = 1'b0; w_cnt = '0; w_data = '0; wt_ready = 1'b0;
    exp_proto = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wt_vld !== 1'b0 || wt_idx !== 6'd0 || wt_data !== 32'd0 || hash_done !== 1'b0 ||
        busy !== 1'b0 || proto_err !== 1'b0 || dbg_state !== LOAD) begin
      failures++;
      $display("FAIL reset_state: got vld=%b idx=%0d data=%08h done=%b busy=%b perr=%b st=%0d, want all 0",
               wt_vld, wt_idx, wt_data, hash_done, busy, proto_err, dbg_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_abc();
    blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = 32'd0;
    blk[15] = 32'h00000018;
    build_gold();
    load_block();
    consume_block("abc", 1'b0, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) blk[i] = 32'h01010101 * 32'(i + 1);
    build_gold();
    load_block();
    consume_block("b2b_a", 1'b0, -1, 1'b0);
    // Second block starts at the first cycle back in LOAD.
    for (int i = 0; i < 16; i++) blk[i] = ~(32'h10203040 + 32'(i * 7));
    build_gold();
    load_block();
    consume_block("b2b_b", 1'b0, -1, 1'b0);
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_gold();
    load_block();
    consume_block("rand_stall", 1'b1, -1, 1'b0);
  endtask

  task automatic test_dup_index();
    for (int i = 0; i < 16; i++) blk[i] = 32'hc0de0000 | 32'(i);
    for (int i = 0; i < 15; i++) load_word(i, (i == 3) ? 32'haaaaaaaa : blk[i]);
    load_word(3, 32'hbbbbbbbb);
    blk[3] = 32'hbbbbbbbb;
    checks++;
    if (wt_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL dup_before_15: got wt_vld=%b busy=%b, want 0 0", wt_vld, busy);
    end
    load_word(15, blk[15]);
    build_gold();
    consume_block("dup_index", 1'b0, -1, 1'b0);
  endtask

  task automatic test_proto_err();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_gold();
    load_block();
    consume_block("proto_err", 1'b0, 20, 1'b0);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_sticky: got %b, want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 16; i++) blk[i] = 32'h55aa0000 ^ 32'(i * 977);
    build_gold();
    load_block();
    wt_ready = 1'b1;
    cyc = 0;
    while (wt_idx != 6'd30 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (wt_vld !== 1'b1 || wt_idx !== 6'd30 || wt_data !== gold[30]) begin
      failures++;
      $display("FAIL reset_mid_t30: got vld=%b idx=%0d data=%08h, want 1 30 %08h",
               wt_vld, wt_idx, wt_data, gold[30]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_proto = 1'b0;
    checks++;
    if (wt_vld !== 1'b0 || hash_done !== 1'b0 || busy !== 1'b0 || wt_idx !== 6'd0 ||
        proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after: got vld=%b done=%b busy=%b idx=%0d perr=%b, want all 0",
               wt_vld, hash_done, busy, wt_idx, proto_err);
    end
    @(posedge clk); #1;
    checks++;
    if (hash_done !== 1'b0 || wt_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got done=%b vld=%b, want 0 0", hash_done, wt_vld);
    end
    for (int i = 0; i < 16; i++) blk[i] = 32'h12345678 + 32'(i * 32'h01000193);
    build_gold();
    load_block();
    consume_block("after_reset", 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_back_to_back();
    test_random_stall();
    test_dup_index();
    test_proto_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
